// File: rtl/nn_ram_banked.sv
// Banked P / TP / W storage for the digit detector: registered reads with write-first bypass,
// range protection, a saturating accumulate pipe and a TP clear sweep.
module nn_ram_banked #(
    parameter int SIZE_1             = 11,
    parameter int SIZE_2             = 22,
    parameter int SIZE_9             = 99,
    parameter int DEPTH_P            = 6272,
    parameter int DEPTH_TP           = 3136,
    parameter int DEPTH_W            = 257,
    parameter int SIZE_address_pix   = 13,
    parameter int SIZE_address_pix_t = 12,
    parameter int SIZE_address_wei   = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          we_p,
    input  logic                          re_p,
    input  logic [SIZE_address_pix-1:0]   write_addressp,
    input  logic [SIZE_address_pix-1:0]   read_addressp,
    input  logic signed [SIZE_1-1:0]      dp,
    input  logic                          we_tp,
    input  logic                          re_tp,
    input  logic [SIZE_address_pix_t-1:0] write_addresstp,
    input  logic [SIZE_address_pix_t-1:0] read_addresstp,
    input  logic signed [SIZE_2-1:0]      dtp,
    input  logic                          acc_tp,
    input  logic                          clr_tp,
    input  logic                          we_w,
    input  logic                          re_w,
    input  logic [SIZE_address_wei-1:0]   write_addressw,
    input  logic [SIZE_address_wei-1:0]   read_addressw,
    input  logic signed [SIZE_9-1:0]      dw,
    output logic signed [SIZE_1-1:0]      qp,
    output logic signed [SIZE_2-1:0]      qtp,
    output logic signed [SIZE_9-1:0]      qw,
    output logic                          qp_valid,
    output logic                          qtp_valid,
    output logic                          qw_valid,
    output logic                          busy_tp,
    output logic                          clr_done,
    output logic                          addr_err
);
    localparam int AP = SIZE_address_pix;
    localparam int AT = SIZE_address_pix_t;
    localparam int AW = SIZE_address_wei;
    localparam logic [AP:0] LIM_P = (AP+1)'(DEPTH_P);
    localparam logic [AT:0] LIM_T = (AT+1)'(DEPTH_TP);
    localparam logic [AW:0] LIM_W = (AW+1)'(DEPTH_W);
    localparam logic [AT-1:0] CNT_LAST = AT'(DEPTH_TP - 1);
    localparam logic [SIZE_2-1:0] SAT_MAX = {1'b0, {(SIZE_2-1){1'b1}}};
    localparam logic [SIZE_2-1:0] SAT_MIN = {1'b1, {(SIZE_2-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} clr_state_e;

    logic signed [SIZE_1-1:0] mem_p  [DEPTH_P];
    logic signed [SIZE_2-1:0] mem_tp [DEPTH_TP];
    logic signed [SIZE_9-1:0] mem_w  [DEPTH_W];

    clr_state_e state_q;
    logic [AT-1:0] cnt_q;
    logic busy_q, done_q;

    logic signed [SIZE_1-1:0] qp_q, qp_d;
    logic signed [SIZE_2-1:0] qtp_q, qtp_d;
    logic signed [SIZE_9-1:0] qw_q, qw_d;
    logic qp_valid_q, qp_valid_d, qtp_valid_q, qtp_valid_d;
    logic qw_valid_q, qw_valid_d, addr_err_q, addr_err_d;
    logic acc_v_q, acc_v_d;
    logic [AT-1:0] acc_a_q, acc_a_d;
    logic signed [SIZE_2-1:0] acc_d_q, acc_d_d, acc_old_q, acc_old_d;

    logic p_w_ok, p_r_ok, t_w_ok, t_r_ok, w_w_ok, w_r_ok;
    logic sweep, wa_en, wb_en, acc_go;
    logic [AT-1:0] wa_addr;
    logic signed [SIZE_2-1:0] wa_data, acc_sum, tp_rd_next, tp_acc_next;
    logic [SIZE_2:0] acc_wide;

    assign p_w_ok = {1'b0, write_addressp} < LIM_P;
    assign p_r_ok = {1'b0, read_addressp} < LIM_P;
    assign t_w_ok = {1'b0, write_addresstp} < LIM_T;
    assign t_r_ok = {1'b0, read_addresstp} < LIM_T;
    assign w_w_ok = {1'b0, write_addressw} < LIM_W;
    assign w_r_ok = {1'b0, read_addressw} < LIM_W;

    // TP port A carries plain writes or the sweep; port B retires accumulates
    assign sweep   = (state_q == SWEEP);
    assign wa_en   = sweep | (we_tp & ~acc_tp & t_w_ok);
    assign wa_addr = sweep ? cnt_q : write_addresstp;
    assign wa_data = sweep ? '0 : dtp;
    assign acc_go  = we_tp & acc_tp & t_w_ok & ~sweep;
    assign wb_en   = acc_v_q & ~(wa_en & (wa_addr == acc_a_q));

    assign acc_wide = {acc_old_q[SIZE_2-1], acc_old_q} + {acc_d_q[SIZE_2-1], acc_d_q};
    assign acc_sum  = (acc_wide[SIZE_2] ^ acc_wide[SIZE_2-1])
                    ? (acc_wide[SIZE_2] ? SAT_MIN : SAT_MAX)
                    : acc_wide[SIZE_2-1:0];

    // Value a TP location holds after the current edge (write-first view)
    always_comb begin
        tp_rd_next = mem_tp[read_addresstp];
        if (wa_en && wa_addr == read_addresstp)
            tp_rd_next = wa_data;
        else if (wb_en && acc_a_q == read_addresstp)
            tp_rd_next = acc_sum;
        tp_acc_next = mem_tp[write_addresstp];
        if (wa_en && wa_addr == write_addresstp)
            tp_acc_next = wa_data;
        else if (wb_en && acc_a_q == write_addresstp)
            tp_acc_next = acc_sum;
    end

    always_comb begin
        qp_d = qp_q;
        qtp_d = qtp_q;
        qw_d = qw_q;
        if (re_p)
            qp_d = !p_r_ok ? '0
                 : (we_p && p_w_ok && write_addressp == read_addressp) ? dp
                 : mem_p[read_addressp];
        if (re_tp)
            qtp_d = t_r_ok ? tp_rd_next : '0;
        if (re_w)
            qw_d = !w_r_ok ? '0
                 : (we_w && w_w_ok && write_addressw == read_addressw) ? dw
                 : mem_w[read_addressw];
        qp_valid_d = re_p;
        qtp_valid_d = re_tp;
        qw_valid_d = re_w;
        addr_err_d = addr_err_q
                   | (we_p & ~p_w_ok) | (re_p & ~p_r_ok)
                   | (we_tp & ~t_w_ok) | (re_tp & ~t_r_ok)
                   | (we_w & ~w_w_ok) | (re_w & ~w_r_ok);
        acc_v_d = acc_go;
        acc_a_d = acc_a_q;
        acc_d_d = acc_d_q;
        acc_old_d = acc_old_q;
        if (acc_go) begin
            acc_a_d = write_addresstp;
            acc_d_d = dtp;
            acc_old_d = tp_acc_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qp_q <= '0;
            qtp_q <= '0;
            qw_q <= '0;
            qp_valid_q <= 1'b0;
            qtp_valid_q <= 1'b0;
            qw_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
            acc_v_q <= 1'b0;
            acc_a_q <= '0;
            acc_d_q <= '0;
            acc_old_q <= '0;
        end else begin
            qp_q <= qp_d;
            qtp_q <= qtp_d;
            qw_q <= qw_d;
            qp_valid_q <= qp_valid_d;
            qtp_valid_q <= qtp_valid_d;
            qw_valid_q <= qw_valid_d;
            addr_err_q <= addr_err_d;
            acc_v_q <= acc_v_d;
            acc_a_q <= acc_a_d;
            acc_d_q <= acc_d_d;
            acc_old_q <= acc_old_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    state_q <= IDLE;
                    if (clr_tp) begin
                        state_q <= SWEEP;
                        cnt_q <= '0;
                        busy_q <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (we_p && p_w_ok)
            mem_p[write_addressp] <= dp;
        if (we_w && w_w_ok)
            mem_w[write_addressw] <= dw;
        if (wb_en)
            mem_tp[acc_a_q] <= acc_sum;
        if (wa_en)
            mem_tp[wa_addr] <= wa_data;
    end

    assign qp = qp_q;
    assign qtp = qtp_q;
    assign qw = qw_q;
    assign qp_valid = qp_valid_q;
    assign qtp_valid = qtp_valid_q;
    assign qw_valid = qw_valid_q;
    assign busy_tp = busy_q;
    assign clr_done = done_q;
    assign addr_err = addr_err_q;
endmodule

// File: tb/tb_nn_ram_banked.sv
// Bench for nn_ram_banked: directed scenarios plus random traffic
// checked every cycle against an array-level reference model.
module tb_nn_ram_banked;
    localparam int S1 = 11, S2 = 22, S9 = 99;
    localparam int DP = 6272, DT = 3136, DW = 257;
    localparam int AP = 13, AT = 12, AW = 9;
    localparam longint SMAX = (longint'(1) << (S2 - 1)) - 1;
    localparam longint SMIN = -(longint'(1) << (S2 - 1));

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic we_p, re_p, we_tp, re_tp, acc_tp, clr_tp, we_w, re_w;
    logic [AP-1:0] write_addressp, read_addressp;
    logic [AT-1:0] write_addresstp, read_addresstp;
    logic [AW-1:0] write_addressw, read_addressw;
    logic signed [S1-1:0] dp, qp;
    logic signed [S2-1:0] dtp, qtp;
    logic signed [S9-1:0] dw, qw;
    logic qp_valid, qtp_valid, qw_valid, busy_tp, clr_done, addr_err;

    nn_ram_banked dut (
        .clk(clk), .rst(rst),
        .we_p(we_p), .re_p(re_p),
        .write_addressp(write_addressp), .read_addressp(read_addressp), .dp(dp),
        .we_tp(we_tp), .re_tp(re_tp),
        .write_addresstp(write_addresstp), .read_addresstp(read_addresstp), .dtp(dtp),
        .acc_tp(acc_tp), .clr_tp(clr_tp),
        .we_w(we_w), .re_w(re_w),
        .write_addressw(write_addressw), .read_addressw(read_addressw), .dw(dw),
        .qp(qp), .qtp(qtp), .qw(qw),
        .qp_valid(qp_valid), .qtp_valid(qtp_valid), .qw_valid(qw_valid),
        .busy_tp(busy_tp), .clr_done(clr_done), .addr_err(addr_err)
    );

    logic signed [S1-1:0] mp [DP];
    logic signed [S2-1:0] mtp [DT];
    logic signed [S9-1:0] mw [DW];
    logic signed [S1-1:0] e_qp;
    logic signed [S2-1:0] e_qtp;
    logic signed [S9-1:0] e_qw;
    logic e_qpv, e_qtpv, e_qwv, e_busy, e_done, e_err;
    int e_idx;
    logic pend_v;
    int pend_a;
    logic signed [S2-1:0] pend_val;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 25)
                $display("FAIL %s at %0t: got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic logic signed [S2-1:0] sat(input logic signed [S2-1:0] a,
                                                 input logic signed [S2-1:0] b);
        longint s;
        s = longint'(a) + longint'(b);
        if (s > SMAX) s = SMAX;
        if (s < SMIN) s = SMIN;
        return S2'(s);
    endfunction

    function automatic logic signed [S9-1:0] rnd_w();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[S9-1:0];
    endfunction

    function automatic int rnd_a(input int depth, input int aw);
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 75) return int'($urandom_range(0, 7));
        if (r < 96) return int'($urandom_range(0, depth - 1));
        return int'($urandom_range(0, (1 << aw) - 1));
    endfunction

    task automatic model_reset();
        e_qp = '0; e_qtp = '0; e_qw = '0;
        e_qpv = 0; e_qtpv = 0; e_qwv = 0;
        e_busy = 0; e_done = 0; e_err = 0;
        e_idx = 0; pend_v = 0; pend_a = 0; pend_val = '0;
    endtask

    // One clock edge in terms of array contents: pending accumulate retires,
    // then any plain or sweep write overrides it, then reads see the result.
    task automatic model_edge();
        bit b0, pw, pr, tw, tr, ww, wr;
        b0 = e_busy;
        pw = int'(write_addressp) < DP;
        pr = int'(read_addressp) < DP;
        tw = int'(write_addresstp) < DT;
        tr = int'(read_addresstp) < DT;
        ww = int'(write_addressw) < DW;
        wr = int'(read_addressw) < DW;
        if ((we_p && !pw) || (re_p && !pr) || (we_tp && !tw) ||
            (re_tp && !tr) || (we_w && !ww) || (re_w && !wr))
            e_err = 1;
        if (pend_v) mtp[pend_a] = pend_val;
        pend_v = 0;
        if (b0) mtp[e_idx] = '0;
        else if (we_tp && !acc_tp && tw) mtp[write_addresstp] = dtp;
        if (we_p && pw) mp[write_addressp] = dp;
        if (we_w && ww) mw[write_addressw] = dw;
        if (re_p) e_qp = pr ? mp[read_addressp] : '0;
        if (re_tp) e_qtp = tr ? mtp[read_addresstp] : '0;
        if (re_w) e_qw = wr ? mw[read_addressw] : '0;
        e_qpv = re_p; e_qtpv = re_tp; e_qwv = re_w;
        if (!b0 && we_tp && acc_tp && tw) begin
            pend_v = 1;
            pend_a = int'(write_addresstp);
            pend_val = sat(mtp[write_addresstp], dtp);
        end
        e_done = 0;
        if (b0) begin
            e_idx++;
            if (e_idx == DT) begin
                e_busy = 0;
                e_done = 1;
            end
        end else if (clr_tp) begin
            e_busy = 1;
            e_idx = 0;
        end
    endtask

    task automatic check_outs();
        chk("qp", qp, e_qp);
        chk("qp_valid", qp_valid, e_qpv);
        chk("qtp", qtp, e_qtp);
        chk("qtp_valid", qtp_valid, e_qtpv);
        chk("qw", qw, e_qw);
        chk("qw_valid", qw_valid, e_qwv);
        chk("busy_tp", busy_tp, e_busy);
        chk("clr_done", clr_done, e_done);
        chk("addr_err", addr_err, e_err);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check_outs();
    endtask

    task automatic idle();
        we_p = 0; re_p = 0; we_tp = 0; re_tp = 0;
        acc_tp = 0; clr_tp = 0; we_w = 0; re_w = 0;
    endtask

    int nb, nd, nz, guard;

    initial begin
        idle();
        write_addressp = '0; read_addressp = '0; dp = '0;
        write_addresstp = '0; read_addresstp = '0; dtp = '0;
        write_addressw = '0; read_addressw = '0; dw = '0;
        model_reset();
        #1 rst = 1;
        #1 check_outs();
        @(negedge clk) rst = 0;

        // fill every array so all later reads are defined
        for (int i = 0; i < DP; i++) begin
            we_p = 1; write_addressp = AP'(i); dp = S1'($urandom);
            we_tp = (i < DT); write_addresstp = AT'(i % DT); dtp = S2'(1);
            we_w = (i < DW); write_addressw = AW'(i % DW); dw = rnd_w();
            tick();
        end
        idle();

        // P write then read, then same-cycle write/read bypass
        we_p = 1; write_addressp = 5; dp = 37;
        tick();
        we_p = 0; re_p = 1; read_addressp = 5;
        tick();
        chk("p_rd37", qp, 37);
        chk("p_rd37_valid", qp_valid, 1);
        we_p = 1; dp = 12;
        tick();
        chk("p_bypass12", qp, 12);
        idle();
        tick();
        chk("p_valid_drop", qp_valid, 0);
        chk("p_hold", qp, 12);

        // accumulate chain on TP[9]
        we_tp = 1; write_addresstp = 9; dtp = 100;
        tick();
        acc_tp = 1; dtp = 5;
        tick();
        dtp = 7;
        tick();
        dtp = -3;
        tick();
        idle(); re_tp = 1; read_addresstp = 9;
        tick();
        chk("acc_chain", qtp, 109);
        tick();
        chk("acc_chain_arr", qtp, 109);

        // positive saturation on TP[10]
        idle(); we_tp = 1; write_addresstp = 10; dtp = S2'(1 << (S2 - 2));
        tick();
        acc_tp = 1;
        tick();
        tick();
        idle(); re_tp = 1; read_addresstp = 10;
        tick();
        chk("acc_sat", qtp, SMAX[S2-1:0]);

        // clear sweep with dropped writes and live reads
        idle(); clr_tp = 1;
        tick();
        clr_tp = 0;
        nb = 0; nd = 0;
        for (int k = 0; k < DT + 20; k++) begin
            if (busy_tp) nb++;
            if (clr_done) nd++;
            we_tp = e_busy; acc_tp = 1'($urandom);
            write_addresstp = AT'($urandom_range(0, DT - 1)); dtp = S2'($urandom);
            re_tp = 1; read_addresstp = AT'($urandom_range(0, DT - 1));
            re_p = 1; read_addressp = AP'($urandom_range(0, DP - 1));
            re_w = 1; read_addressw = AW'($urandom_range(0, DW - 1));
            tick();
        end
        chk("sweep_busy_len", nb, DT);
        chk("sweep_done_cnt", nd, 1);
        idle();
        nz = 0;
        for (int a = 0; a < DT; a++) begin
            re_tp = 1; read_addresstp = AT'(a);
            tick();
            if (qtp != 0) nz++;
        end
        chk("tp_all_zero", nz, 0);

        // reset in the middle of a sweep
        idle();
        for (int a = 0; a < 200; a++) begin
            we_tp = 1; write_addresstp = AT'(a); dtp = S2'(a + 1);
            tick();
        end
        idle(); clr_tp = 1;
        tick();
        clr_tp = 0;
        guard = 0;
        while (e_idx != 100 && guard < 500) begin
            tick();
            guard++;
        end
        chk("sweep_reach_100", guard < 500, 1);
        rst = 1;
        model_reset();
        #1;
        check_outs();
        chk("rst_busy", busy_tp, 0);
        @(negedge clk) rst = 0;
        re_tp = 1; read_addresstp = 99;
        tick();
        chk("rst_tp99", qtp, 0);
        chk("rst_no_done", clr_done, 0);
        read_addresstp = 100;
        tick();
        chk("rst_tp100", qtp, 101);

        // out-of-range protection and sticky error
        idle(); we_w = 1; write_addressw = AW'(DW); dw = rnd_w();
        tick();
        chk("w_oor_err", addr_err, 1);
        idle(); re_p = 1; read_addressp = AP'(DP);
        tick();
        chk("p_oor_q", qp, 0);
        chk("p_oor_valid", qp_valid, 1);
        for (int k = 0; k < 8; k++) begin
            re_w = 1; read_addressw = AW'(k);
            re_p = 1; read_addressp = AP'(k);
            tick();
        end
        chk("err_sticky", addr_err, 1);

        // random traffic on all ports
        for (int k = 0; k < 5000; k++) begin
            we_p = 1'($urandom); re_p = 1'($urandom);
            write_addressp = AP'(rnd_a(DP, AP)); read_addressp = AP'(rnd_a(DP, AP));
            dp = S1'($urandom);
            we_tp = 1'($urandom); re_tp = 1'($urandom); acc_tp = 1'($urandom);
            write_addresstp = AT'(rnd_a(DT, AT)); read_addresstp = AT'(rnd_a(DT, AT));
            dtp = S2'($urandom);
            clr_tp = ($urandom_range(0, 1999) == 0);
            we_w = 1'($urandom); re_w = 1'($urandom);
            write_addressw = AW'(rnd_a(DW, AW)); read_addressw = AW'(rnd_a(DW, AW));
            dw = rnd_w();
            tick();
        end
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
